touch_adc_sequencer: RTL and testbench
======================================

# touch_adc_sequencer

Sequences the resistive-touch ADC (ADS7843-class, 24-clock SPI frames) for the touch/edit panel. Detects pen-down, runs averaged X/Y conversion bursts, and presents 8-bit coordinates to the touch UI logic. Generates the `transmit_en` session window and the `penirq_n` per-coordinate strobe train that the UI logic clocks on. Sits between the board touch-controller pins and the touch UI/slider logic.

## Interface
Parameters:
- `CLK_DIV`, 16: `sys_clk` cycles per DCLK half-period; minimum 1.
- `SETTLE`, 2000: `sys_clk` cycles waited after pen-down before the first frame.
- `AVG_LOG2`, 2: log2 of samples averaged per axis, giving 4 samples.
- `GAP`, 5000: idle `sys_clk` cycles between coordinate bursts.
- `RELEASE_CNT`, 3: consecutive pen-up gap checks needed to end a session.
- `STROBE_LEN`, 8: low width of `penirq_n`, in `sys_clk` cycles.

Ports:
- `sys_clk`, in, 1: system clock.
- `iRST_n`, in, 1: reset, asynchronous, active-low.
- `adc_penirq_n`, in, 1: raw pen interrupt from the ADC, asynchronous.
- `adc_dout`, in, 1: ADC serial data out.
- `adc_din`, out, 1: ADC serial data in (command).
- `adc_dclk`, out, 1: ADC serial clock.
- `adc_cs_n`, out, 1: ADC chip select.
- `x`, out, 8: averaged X coordinate.
- `y`, out, 8: averaged Y coordinate.
- `new_coord_r`, out, 1: one-cycle pulse when `x`/`y` update.
- `penirq_n`, out, 1: low for `STROBE_LEN` cycles after each coordinate update.
- `transmit_en`, out, 1: high for the duration of a pen session.
- `busy`, out, 1: high while a frame is in progress.

## Operation
- `adc_penirq_n` passes through a 2-flop synchronizer before any use.
- Commands: X = 8'hD0, Y = 8'h90. Both are 12-bit, differential, power-down between conversions.
- Frame layout: `adc_cs_n` low for 24 DCLK periods, numbered 0..23.
  - Command bit 7 first on periods 0..7. `adc_din` changes while DCLK is low.
  - Period 8 is the ADC busy period.
  - `adc_dout` is sampled on DCLK rising edges of periods 9..20, MSB first, into a 12-bit result.
  - Periods 21..23 are ignored.
- FSM states:
  - IDLE: wait for synced pen low → SETTLE.
  - SETTLE: count `SETTLE` cycles → BURST.
  - BURST: 2^AVG_LOG2 X frames, then 2^AVG_LOG2 Y frames. Sums accumulate in 14-bit accumulators (12+AVG_LOG2) → PUBLISH.
  - PUBLISH: `x` = xsum[13:6], `y` = ysum[13:6] (upper 8 of the mean, i.e. mean>>4). Pulse `new_coord_r`, start the `penirq_n` low strobe, set `transmit_en` → GAP.
  - GAP: count `GAP` cycles, then check synced pen.
    - Pen low: clear the release counter → BURST.
    - Pen high: increment the release counter.
    - Counter reaches `RELEASE_CNT`: clear `transmit_en` → IDLE. Otherwise → GAP.
- Pen state is evaluated only in IDLE and GAP; `adc_penirq_n` is invalid while `adc_cs_n` is low.
- A burst already started always completes; a publish always follows it.
- `x`/`y` hold their last values outside PUBLISH.
- `transmit_en` falls only from GAP, never within `STROBE_LEN` of a strobe. This ensures the last `penirq_n` edge precedes the `transmit_en` falling edge.

## Timing
- Reset values:
  - `adc_cs_n`=1, `adc_dclk`=0, `adc_din`=0, `busy`=0.
  - `x`=`y`=0, `new_coord_r`=0, `penirq_n`=1, `transmit_en`=0.
  - FSM in IDLE, all counters 0.
- Reset asserted mid-frame: `adc_cs_n` goes high immediately (asynchronously) and the partial frame is discarded.
- Frame length: 48·CLK_DIV `sys_clk` cycles. `adc_cs_n` setup is one DCLK half-period before period 0; hold is one half-period after period 23. There is one half-period CS-high gap between frames.
- Burst-to-publish latency: 2^(AVG_LOG2+1) frames plus 1 cycle. `new_coord_r` is registered, in the same cycle as the `x`/`y` update.
- `transmit_en` rises in the same cycle as the first `new_coord_r` of a session.
- `penirq_n` falls 1 cycle after `new_coord_r` and stays low `STROBE_LEN` cycles. `x`/`y` are stable ≥1 cycle before the falling edge.
- Pen-down edge shorter than synchronizer plus 1 cycle is ignored.

## Structure
- Package `touch_pkg` holds:
  - the state enum `touch_seq_state_t` (IDLE, SETTLE, BURST, PUBLISH, GAP);
  - `CMD_X` and `CMD_Y`;
  - `FRAME_CLKS`=24, `DATA_FIRST`=9, `DATA_BITS`=12.
- Sub-module `touch_spi_frame`:
  - Ports: `start`, `cmd[7:0]` → `done`, `result[11:0]`.
  - Owns the DCLK divider, CS, the shift registers and the period counter.
  - The sequencer owns the FSM, the accumulators, and the gap and release counters.

## Test plan
- **Single frame:** ADC model returns 12'hABC for X. Check `adc_din` sequence 8'hD0, exactly 24 DCLK rises with CS low, and `result`=12'hABC.
- **Averaging:** X samples 100,104,108,112 and Y samples 4000 ×4. Expect `x`=8'h06, `y`=8'hFA, one `new_coord_r`, then `penirq_n` low exactly 8 cycles.
- **Session:** pen held for 3 bursts, then released. Expect 3 strobes, then `transmit_en` falls after exactly 3 pen-up gap checks; the last `penirq_n` rise precedes that fall.
- **Mid-burst release:** pen lifts during the X frames. The burst completes and publishes; `transmit_en` drops after the `RELEASE_CNT` checks.
- **Glitch:** a 1-cycle `adc_penirq_n` low in IDLE. Expect no frame and `adc_cs_n` stays 1.
- **Reset mid-frame:** assert `iRST_n` at DCLK period 12. `adc_cs_n`=1 immediately, all outputs at reset values, and a clean frame on the next pen-down.

Source files
------------

// File: rtl/touch_pkg.sv
// touch_pkg: sequencer states and ADS7843 frame constants shared by the touch ADC logic
package touch_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_BURST, ST_PUBLISH, ST_GAP} touch_seq_state_t;
  localparam logic [7:0] CMD_X = 8'hD0;
  localparam logic [7:0] CMD_Y = 8'h90;
  localparam int FRAME_CLKS = 24;
  localparam int DATA_FIRST = 9;
  localparam int DATA_BITS = 12;
endpackage

// File: rtl/touch_adc_sequencer_if.sv
// touch_adc_sequencer_if: board-level serial link to the touch ADC
interface touch_adc_sequencer_if;
  logic adc_penirq_n;
  logic adc_dout;
  logic adc_din;
  logic adc_dclk;
  logic adc_cs_n;
  modport master(input adc_penirq_n, adc_dout, output adc_din, adc_dclk, adc_cs_n);
  modport slave(output adc_penirq_n, adc_dout, input adc_din, adc_dclk, adc_cs_n);
endinterface

// File: rtl/touch_spi_frame.sv
// touch_spi_frame: one 24-DCLK ADC frame, command out and 12-bit result in
module touch_spi_frame import touch_pkg::*; #(
  parameter int CLK_DIV = 16
) (
  input  logic        sys_clk,
  input  logic        iRST_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic        adc_dout,
  output logic        adc_din,
  output logic        adc_dclk,
  output logic        adc_cs_n,
  output logic        done,
  output logic        busy,
  output logic [11:0] result
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [5:0] HP = 6'(2 * FRAME_CLKS);
  localparam logic [4:0] DF = 5'(DATA_FIRST);
  localparam logic [4:0] DL = 5'(DATA_FIRST + DATA_BITS);
  logic [DW-1:0] div;
  logic [5:0] hp, hn;
  logic [4:0] p;
  logic [7:0] cmd_r;
  logic [11:0] sh;
  logic tick;
  assign tick = div == DW'(CLK_DIV - 1);
  assign hn = hp + 6'd1;
  assign p = hn[5:1];
  // half-period stepper: half 0 is CS setup, odd halves raise DCLK, half 48 is CS hold, half 49 the CS-high gap
  always_ff @(posedge sys_clk or negedge iRST_n)
    if (!iRST_n) begin
      busy <= 1'b0;
      div <= '0;
      hp <= '0;
      cmd_r <= '0;
      sh <= '0;
      result <= '0;
      done <= 1'b0;
      adc_cs_n <= 1'b1;
      adc_dclk <= 1'b0;
      adc_din <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy <= 1'b1;
          div <= '0;
          hp <= '0;
          cmd_r <= cmd;
          adc_cs_n <= 1'b0;
          adc_din <= cmd[7];
        end
      end else if (!tick) begin
        div <= div + 1'b1;
      end else begin
        div <= '0;
        hp <= hn;
        adc_dclk <= hn < HP && hn[0];
        adc_cs_n <= hn > HP;
        if (!hn[0]) adc_din <= p < 5'd8 ? cmd_r[~p[2:0]] : 1'b0;
        if (hn[0] && p >= DF && p < DL) sh <= {sh[10:0], adc_dout};
        if (hn == HP + 6'd2) begin
          busy <= 1'b0;
          done <= 1'b1;
          result <= sh;
        end
      end
    end
endmodule

// File: rtl/touch_adc_sequencer.sv
// touch_adc_sequencer: pen detection, averaged X/Y bursts and UI strobes for an ADS7843-class touch ADC
module touch_adc_sequencer import touch_pkg::*; #(
  parameter int CLK_DIV = 16,
  parameter int SETTLE = 2000,
  parameter int AVG_LOG2 = 2,
  parameter int GAP = 5000,
  parameter int RELEASE_CNT = 3,
  parameter int STROBE_LEN = 8
) (
  input  logic                         sys_clk,
  input  logic                         iRST_n,
  touch_adc_sequencer_if.master        adc,
  output logic [7:0]                   x,
  output logic [7:0]                   y,
  output logic                         new_coord_r,
  output logic                         penirq_n,
  output logic                         transmit_en,
  output logic                         busy
);
  localparam int SW = 12 + AVG_LOG2;
  localparam int TW = $clog2((SETTLE > GAP ? SETTLE : GAP) + 1);
  localparam int RW = $clog2(RELEASE_CNT + 1);
  localparam int PW = $clog2(STROBE_LEN + 1);
  touch_seq_state_t state, state_next;
  logic [2:0] pen_s;
  logic pen_down, start, done, clr, gap_end, rel_last, req;
  logic [TW-1:0] cnt;
  logic [RW-1:0] rel;
  logic [PW-1:0] scnt;
  logic [AVG_LOG2:0] fcnt;
  logic [SW-1:0] xsum, ysum;
  logic [11:0] result;
  touch_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
    .sys_clk(sys_clk),
    .iRST_n(iRST_n),
    .start(start),
    .cmd(fcnt[AVG_LOG2] ? CMD_Y : CMD_X),
    .adc_dout(adc.adc_dout),
    .adc_din(adc.adc_din),
    .adc_dclk(adc.adc_dclk),
    .adc_cs_n(adc.adc_cs_n),
    .done(done),
    .busy(busy),
    .result(result)
  );
  // pen must read low on two consecutive synchronized samples, so single-cycle glitches never start a session
  assign pen_down = !pen_s[1] && !pen_s[2];
  assign gap_end = state == ST_GAP && cnt == TW'(GAP - 1);
  assign rel_last = rel == RW'(RELEASE_CNT - 1);
  assign clr = state == ST_IDLE || state_next != state || gap_end;
  // state register
  always_ff @(posedge sys_clk or negedge iRST_n)
    if (!iRST_n) state <= ST_IDLE;
    else state <= state_next;
  // next state and frame launch; a started burst runs to completion regardless of the pen
  always_comb begin
    state_next = state;
    start = 1'b0;
    case (state)
      ST_IDLE: state_next = pen_down ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: state_next = cnt == TW'(SETTLE - 1) ? ST_BURST : ST_SETTLE;
      ST_BURST: begin
        start = !req;
        state_next = done && &fcnt ? ST_PUBLISH : ST_BURST;
      end
      ST_PUBLISH: state_next = ST_GAP;
      ST_GAP: state_next = !gap_end ? ST_GAP : pen_down ? ST_BURST : rel_last ? ST_IDLE : ST_GAP;
      default: state_next = ST_IDLE;
    endcase
  end
  // synchronizer, timers, release count and X-then-Y accumulation
  always_ff @(posedge sys_clk or negedge iRST_n)
    if (!iRST_n) begin
      pen_s <= '1;
      cnt <= '0;
      rel <= '0;
      req <= 1'b0;
      fcnt <= '0;
      xsum <= '0;
      ysum <= '0;
    end else begin
      pen_s <= {pen_s[1:0], adc.adc_penirq_n};
      cnt <= clr ? '0 : cnt + 1'b1;
      rel <= !gap_end ? rel : pen_down || rel_last ? '0 : rel + 1'b1;
      req <= start || (req && !done);
      fcnt <= state != ST_BURST ? '0 : done ? fcnt + 1'b1 : fcnt;
      xsum <= state != ST_BURST ? '0 : done && !fcnt[AVG_LOG2] ? xsum + SW'(result) : xsum;
      ysum <= state != ST_BURST ? '0 : done && fcnt[AVG_LOG2] ? ysum + SW'(result) : ysum;
    end
  // coordinate publish, session window and the penirq_n strobe that trails new_coord_r by one cycle
  always_ff @(posedge sys_clk or negedge iRST_n)
    if (!iRST_n) begin
      x <= '0;
      y <= '0;
      new_coord_r <= 1'b0;
      transmit_en <= 1'b0;
      penirq_n <= 1'b1;
      scnt <= '0;
    end else begin
      new_coord_r <= state == ST_PUBLISH;
      x <= state == ST_PUBLISH ? xsum[SW-1 -: 8] : x;
      y <= state == ST_PUBLISH ? ysum[SW-1 -: 8] : y;
      transmit_en <= state == ST_PUBLISH || (transmit_en && !(state == ST_GAP && state_next == ST_IDLE));
      penirq_n <= new_coord_r ? 1'b0 : scnt == '0 ? 1'b1 : penirq_n;
      scnt <= new_coord_r ? PW'(STROBE_LEN - 1) : scnt != '0 ? scnt - 1'b1 : scnt;
    end
endmodule

// File: tb/tb_touch_adc_sequencer.sv
// tb_touch_adc_sequencer: directed sessions against a behavioural ADS7843 model
module tb_touch_adc_sequencer;
  localparam int CLK_DIV = 2;
  localparam int SETTLE = 20;
  localparam int AVG_LOG2 = 2;
  localparam int GAP = 300;
  localparam int RELEASE_CNT = 3;
  localparam int STROBE_LEN = 8;
  logic sys_clk = 1'b0;
  logic iRST_n = 1'b0;
  logic [7:0] x, y;
  logic new_coord_r, penirq_n, transmit_en, busy;
  int vecs = 0, errs = 0;
  int ncoord = 0, strobes = 0, low_run = 0, last_low = 0, cyc = 0, coord_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic te_q = 1'b0;
  logic [1:0] te_at_coord = 2'b00;
  int mk = 0, frames = 0, xi = 0, yi = 0, last_k = 0;
  logic [7:0] cmd_sh = 8'h00, last_cmd = 8'h00;
  logic [11:0] mval = 12'h000;
  logic [11:0] xs [4];
  logic [11:0] ys [4];
  logic cs_q = 1'b1, dclk_q = 1'b0;
  touch_adc_sequencer_if adc();
  touch_adc_sequencer #(
    .CLK_DIV(CLK_DIV), .SETTLE(SETTLE), .AVG_LOG2(AVG_LOG2),
    .GAP(GAP), .RELEASE_CNT(RELEASE_CNT), .STROBE_LEN(STROBE_LEN)
  ) dut (
    .sys_clk(sys_clk), .iRST_n(iRST_n), .adc(adc),
    .x(x), .y(y), .new_coord_r(new_coord_r), .penirq_n(penirq_n),
    .transmit_en(transmit_en), .busy(busy)
  );
  always #5 sys_clk = ~sys_clk;
  always @(adc.adc_cs_n or adc.adc_dclk) begin
    if (cs_q && !adc.adc_cs_n) begin
      mk = 0;
      frames++;
    end
    if (!cs_q && adc.adc_cs_n) last_k = mk;
    if (!dclk_q && adc.adc_dclk && !adc.adc_cs_n) begin
      if (mk < 8) cmd_sh = {cmd_sh[6:0], adc.adc_din};
      mk++;
      if (mk == 8) begin
        last_cmd = cmd_sh;
        if (cmd_sh == 8'hD0) begin
          mval = xs[xi % 4];
          xi++;
        end else begin
          mval = ys[yi % 4];
          yi++;
        end
      end
    end
    if (dclk_q && !adc.adc_dclk) adc.adc_dout = (mk >= 9 && mk <= 20) ? mval[20 - mk] : 1'b0;
    cs_q = adc.adc_cs_n;
    dclk_q = adc.adc_dclk;
  end
  always @(negedge sys_clk) begin
    cyc++;
    if (new_coord_r) begin
      ncoord++;
      coord_cyc = cyc;
      te_at_coord = {te_q, transmit_en};
    end
    if (!penirq_n) low_run++;
    else if (low_run != 0) begin
      last_low = low_run;
      low_run = 0;
      strobes++;
      rise_cyc = cyc;
    end
    if (te_q && !transmit_en) fall_cyc = cyc;
    te_q = transmit_en;
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  function automatic bit probe(input int w);
    case (w)
      0: return new_coord_r;
      1: return dut.u_frame.done;
      2: return !transmit_en;
      3: return !adc.adc_cs_n;
      default: return mk >= 12;
    endcase
  endfunction
  task automatic wait_on(input string tag, input int w, input int lim);
    int n = 0;
    while (!probe(w) && n < lim) begin
      @(negedge sys_clk);
      n++;
    end
    chk(tag, n < lim, 1);
  endtask
  initial begin
    int n0, s0;
    adc.adc_penirq_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xs[i] = 12'hABC;
      ys[i] = 12'h123;
    end
    repeat (3) @(negedge sys_clk);
    chk("rst_ctl", {adc.adc_cs_n, adc.adc_dclk, adc.adc_din, busy, new_coord_r, penirq_n, transmit_en}, 7'b1000010);
    chk("rst_xy", {x, y}, 16'h0000);
    iRST_n = 1'b1;
    @(negedge sys_clk);
    adc.adc_penirq_n = 1'b0;
    wait_on("frame_done", 1, 2000);
    chk("frame_result", dut.u_frame.result, 12'hABC);
    chk("frame_cmd", last_cmd, 8'hD0);
    chk("frame_rises", last_k, 24);
    wait_on("coord_a", 0, 3000);
    chk("coord_a_xy", {x, y}, 16'hAB12);
    adc.adc_penirq_n = 1'b1;
    wait_on("te_fall_a", 2, 2000);
    xs = '{12'd100, 12'd104, 12'd108, 12'd112};
    for (int i = 0; i < 4; i++) ys[i] = 12'd4000;
    n0 = ncoord;
    s0 = strobes;
    adc.adc_penirq_n = 1'b0;
    wait_on("coord_b", 0, 3000);
    chk("avg_x", x, 8'h06);
    chk("avg_y", y, 8'hFA);
    adc.adc_penirq_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    chk("strobe_width", last_low, 8);
    chk("coord_b_count", ncoord - n0, 1);
    chk("strobe_b_count", strobes - s0, 1);
    wait_on("te_fall_b", 2, 2000);
    for (int i = 0; i < 4; i++) begin
      xs[i] = 12'h800;
      ys[i] = 12'h400;
    end
    n0 = ncoord;
    s0 = strobes;
    adc.adc_penirq_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_on("coord_c", 0, 3000);
      @(negedge sys_clk);
      if (i == 0) chk("te_rise_with_coord", te_at_coord, 2'b01);
    end
    adc.adc_penirq_n = 1'b1;
    chk("coord_c_xy", {x, y}, 16'h8040);
    wait_on("te_fall_c", 2, 2000);
    @(negedge sys_clk);
    chk("release_c_cycles", fall_cyc - coord_cyc, 3 * GAP);
    chk("strobe_c_count", strobes - s0, 3);
    chk("coord_c_count", ncoord - n0, 3);
    chk("strobe_before_fall", rise_cyc < fall_cyc, 1);
    n0 = ncoord;
    adc.adc_penirq_n = 1'b0;
    wait_on("cs_d", 3, 200);
    adc.adc_penirq_n = 1'b1;
    wait_on("coord_d", 0, 3000);
    chk("coord_d_x", x, 8'h80);
    wait_on("te_fall_d", 2, 2000);
    @(negedge sys_clk);
    chk("release_d_cycles", fall_cyc - coord_cyc, 3 * GAP);
    chk("coord_d_count", ncoord - n0, 1);
    n0 = frames;
    repeat (5) @(negedge sys_clk);
    adc.adc_penirq_n = 1'b0;
    @(negedge sys_clk);
    adc.adc_penirq_n = 1'b1;
    repeat (200) @(negedge sys_clk);
    chk("glitch_frames", frames - n0, 0);
    chk("glitch_cs", {adc.adc_cs_n, busy}, 2'b10);
    for (int i = 0; i < 4; i++) xs[i] = 12'hABC;
    adc.adc_penirq_n = 1'b0;
    wait_on("mid_frame", 4, 500);
    iRST_n = 1'b0;
    #1;
    chk("rst_mid_cs", adc.adc_cs_n, 1);
    chk("rst_mid_ctl", {adc.adc_cs_n, adc.adc_dclk, adc.adc_din, busy, new_coord_r, penirq_n, transmit_en}, 7'b1000010);
    chk("rst_mid_xy", {x, y}, 16'h0000);
    adc.adc_penirq_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    iRST_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    adc.adc_penirq_n = 1'b0;
    wait_on("frame_f", 1, 2000);
    chk("frame_f_result", dut.u_frame.result, 12'hABC);
    chk("frame_f_rises", last_k, 24);
    adc.adc_penirq_n = 1'b1;
    wait_on("coord_f", 0, 3000);
    chk("coord_f_x", x, 8'hAB);
    wait_on("te_fall_f", 2, 2000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
